memory_reader: RTL and testbench

MEMORY_READER -- requirements
Module: memory_reader

---
 rtl/memory_reader.sv | 207 ++++++++++++++++++++
 tb/tb_memory_reader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_reader.sv
// memory_reader: fetches a frame from memory one AXI read burst per line and
// replays it as an AXI-Stream pixel stream with start-of-frame and end-of-line
// flags generated from output-side counters.
module memory_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [15:0]           frame_height,
  input  logic [15:0]           frame_width,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  rd_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           width_q, width_d;
  logic [15:0]           height_q, height_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic [15:0]           line_cnt_q, line_cnt_d;
  logic [15:0]           out_col_q, out_col_d;
  logic [15:0]           out_line_q, out_line_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  rd_error_q, rd_error_d;
  logic                  frame_done_q, frame_done_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic beat_acc, last_beat, pix_acc, last_col, last_pix, fifo_full, fifo_empty;
  logic unused_rid;

  assign unused_rid = ^rid;

  assign fifo_full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign rready        = (state_q == ST_DATA) && !fifo_full;
  assign beat_acc      = rvalid && rready;
  assign last_beat     = (beat_cnt_q == width_q - 16'd1);
  assign m_axis_tvalid = !fifo_empty;
  assign pix_acc       = m_axis_tvalid && m_axis_tready;
  assign last_col      = (out_col_q == width_q - 16'd1);
  assign last_pix      = last_col && (out_line_q == height_q - 16'd1);

  assign arid         = '0;
  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign arvalid      = (state_q == ST_ADDR);
  assign araddr       = araddr_q;
  assign arlen        = arlen_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;
  assign rd_error     = rd_error_q;
  // Data is forced to zero while empty so the stream reads 0 out of reset.
  assign m_axis_tdata = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign m_axis_tuser = m_axis_tvalid && (out_col_q == 16'd0) && (out_line_q == 16'd0);
  assign m_axis_tlast = m_axis_tvalid && last_col;

  // Read FSM: frame capture, one burst per line, beat counting, error tracking.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    beat_cnt_d = beat_cnt_q;
    line_cnt_d = line_cnt_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    rd_error_d = rd_error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_ready) begin
          width_d    = frame_width;
          height_d   = frame_height;
          araddr_d   = base_addr_in;
          arlen_d    = 8'(frame_width - 16'd1);
          beat_cnt_d = '0;
          line_cnt_d = '0;
          rd_error_d = 1'b0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_acc) begin
          // The internal count defines the line end; rlast is only cross-checked.
          if ((rresp != 2'b00) || (rlast != last_beat)) rd_error_d = 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            if (line_cnt_q == height_q - 16'd1) begin
              state_d = ST_DONE;
            end else begin
              line_cnt_d = line_cnt_q + 16'd1;
              araddr_d   = araddr_q + (ADDR_WIDTH'(width_q) << 2);
              state_d    = ST_ADDR;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
        end
      end
      ST_DONE: begin
        if (pix_acc && last_pix) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output side: FIFO pointers and the column/line counters behind tuser/tlast.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_col_d    = out_col_q;
    out_line_d   = out_line_q;
    frame_done_d = 1'b0;
    if (beat_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pix_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (last_col) begin
        out_col_d = '0;
        if (last_pix) begin
          out_line_d   = '0;
          frame_done_d = 1'b1;
        end else begin
          out_line_d = out_line_q + 16'd1;
        end
      end else begin
        out_col_d = out_col_q + 16'd1;
      end
    end
    count_d = count_q + (PTR_W+1)'(beat_acc) - (PTR_W+1)'(pix_acc);
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      beat_cnt_q   <= '0;
      line_cnt_q   <= '0;
      out_col_q    <= '0;
      out_line_q   <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      rd_error_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      beat_cnt_q   <= beat_cnt_d;
      line_cnt_q   <= line_cnt_d;
      out_col_q    <= out_col_d;
      out_line_q   <= out_line_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      rd_error_q   <= rd_error_d;
      frame_done_q <= frame_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; emptiness is tracked by count_q alone.
    if (beat_acc) fifo_mem[wr_ptr_q] <= rdata;
  end

endmodule

// File: tb/tb_memory_reader.sv
// tb_memory_reader: AXI read slave model plus stream scoreboard for memory_reader.
module tb_memory_reader;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_ready = 1'b0;
  logic [AW-1:0] base_addr_in = '0;
  logic [15:0]   frame_height = '0;
  logic [15:0]   frame_width = '0;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [IW-1:0] rid = '0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          busy;
  logic          frame_done;
  logic          rd_error;

  memory_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .base_addr_in(base_addr_in),
    .frame_height(frame_height), .frame_width(frame_width),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .frame_done(frame_done), .rd_error(rd_error)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; logic last; logic user; logic fin;} pix_t;
  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;

  pix_t exp_q[$];
  ar_t  exp_ar[$];
  ar_t  burst_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  // Scenario knobs, written by the test tasks.
  int ar_delay = 0;
  int r_gap = 0;
  int err_beat = -1;
  bit tready_toggle = 0;

  // Observations shared with the test tasks.
  int done_count = 0;
  bit saw_stall = 0;
  int global_beat = 0;

  // Memory contents: each word holds its word address plus one.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  // Bus process: at each falling edge pick inputs for the next rising edge and
  // score the handshakes that edge will complete (DUT outputs are registered).
  initial begin : bus
    bit          b_active;
    logic [31:0] b_addr;
    int          b_len, b_idx, gap_cnt, ar_wait;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    bit          done_expect, prev_stall;
    pix_t        prev_out, e;
    ar_t         a;
    b_active = 0; gap_cnt = 0; ar_wait = 0; done_expect = 0; prev_stall = 0;
    b_addr = '0; b_len = 0; b_idx = 0; hold_addr = '0; hold_len = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_active = 0; gap_cnt = 0; ar_wait = 0; done_expect = 0; prev_stall = 0;
        burst_q.delete();
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        continue;
      end

      // frame_done must follow the final-pixel edge exactly, with busy low.
      if (done_expect || frame_done === 1'b1) begin
        tests_run++;
        if (!done_expect || frame_done !== 1'b1 || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL frame_done: frame_done=%b busy=%b, required frame_done=%b busy=0",
                   frame_done, busy, done_expect);
        end
        if (frame_done === 1'b1) done_count++;
        done_expect = 0;
      end

      // Read data channel.
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (!b_active && burst_q.size() != 0) begin
        a = burst_q.pop_front();
        b_active = 1; b_addr = a.addr; b_len = int'(a.len); b_idx = 0;
      end
      if (b_active) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          rvalid = 1'b1;
          rdata  = mem_word(b_addr + 32'(b_idx * 4));
          rlast  = (b_idx == b_len);
          rresp  = (global_beat == err_beat) ? 2'b10 : 2'b00;
          if (rready === 1'b1) begin
            b_idx++; global_beat++; gap_cnt = r_gap;
            if (b_idx > b_len) b_active = 0;
          end else begin
            saw_stall = 1;
          end
        end
      end

      // Read address channel.
      arready = 1'b0;
      if (arvalid === 1'b1) begin
        if (ar_wait == 0) begin
          hold_addr = araddr; hold_len = arlen;
        end else begin
          tests_run++;
          if (araddr !== hold_addr || arlen !== hold_len) begin
            tests_failed++;
            $display("FAIL ar_stable: araddr=%h arlen=%0d, required %h/%0d", araddr, arlen, hold_addr, hold_len);
          end
        end
        if (ar_wait >= ar_delay) begin
          arready = 1'b1; ar_wait = 0;
          tests_run++;
          if (exp_ar.size() == 0) begin
            tests_failed++;
            $display("FAIL ar_burst: unexpected burst araddr=%h arlen=%0d, required none", araddr, arlen);
          end else begin
            a = exp_ar.pop_front();
            if (araddr !== a.addr || arlen !== a.len) begin
              tests_failed++;
              $display("FAIL ar_burst: araddr=%h arlen=%0d, required %h/%0d", araddr, arlen, a.addr, a.len);
            end
          end
          a.addr = araddr; a.len = arlen;
          burst_q.push_back(a);
        end else begin
          ar_wait++;
        end
      end else begin
        ar_wait = 0;
      end

      // Pixel stream.
      m_axis_tready = tready_toggle ? ~m_axis_tready : 1'b1;
      if (prev_stall) begin
        tests_run++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !==
            {1'b1, prev_out.data, prev_out.last, prev_out.user}) begin
          tests_failed++;
          $display("FAIL stream_stable: v=%b d=%h l=%b u=%b, required v=1 d=%h l=%b u=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                   prev_out.data, prev_out.last, prev_out.user);
        end
      end
      prev_stall = 0;
      if (m_axis_tvalid === 1'b1) begin
        if (m_axis_tready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL pixel: unexpected d=%h, required none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== {e.data, e.last, e.user}) begin
              tests_failed++;
              $display("FAIL pixel: d=%h l=%b u=%b, required d=%h l=%b u=%b",
                       m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
            end
            if (e.fin) done_expect = 1;
          end
        end else begin
          prev_stall = 1;
          prev_out.data = m_axis_tdata; prev_out.last = m_axis_tlast; prev_out.user = m_axis_tuser;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Pulse frame_ready; when the frame is expected to run, queue its bursts and pixels.
  task automatic pulse_frame(input logic [31:0] base, input int w, input int h, input bit expect_it);
    ar_t  a;
    pix_t p;
    logic [31:0] addr;
    tick(1);
    frame_ready = 1'b1; base_addr_in = base; frame_width = 16'(w); frame_height = 16'(h);
    if (expect_it) begin
      global_beat = 0;
      for (int l = 0; l < h; l++) begin
        a.addr = base + 32'(l * w * 4); a.len = 8'(w - 1);
        exp_ar.push_back(a);
        for (int c = 0; c < w; c++) begin
          addr   = base + 32'((l * w + c) * 4);
          p.data = (addr >> 2) + 32'd1;
          p.last = (c == w - 1);
          p.user = (l == 0) && (c == 0);
          p.fin  = (l == h - 1) && (c == w - 1);
          exp_q.push_back(p);
        end
      end
    end
    tick(1);
    frame_ready = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start, n;
    start = done_count; n = 0;
    while (done_count == start && n < budget) begin tick(1); n++; end
    tests_run++;
    if (done_count == start) begin
      tests_failed++;
      $display("FAIL %s_timeout: no frame_done in %0d cycles, required one", name, budget);
    end
    tests_run++;
    if (exp_q.size() != 0 || exp_ar.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d pixels and %0d bursts outstanding, required 0/0", name, exp_q.size(), exp_ar.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if ({arvalid, rready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, frame_done, rd_error} !== 8'b0) begin
      tests_failed++;
      $display("FAIL %s_ctrl: arv=%b rr=%b tv=%b tl=%b tu=%b busy=%b done=%b err=%b, required all 0",
               name, arvalid, rready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, frame_done, rd_error);
    end
    tests_run++;
    if ({araddr, arlen, m_axis_tdata} !== '0) begin
      tests_failed++;
      $display("FAIL %s_data: araddr=%h arlen=%h tdata=%h, required 0", name, araddr, arlen, m_axis_tdata);
    end
    tests_run++;
    if ({arid, arsize, arburst} !== {4'h0, 3'b010, 2'b01}) begin
      tests_failed++;
      $display("FAIL %s_const: arid=%h arsize=%b arburst=%b, required 0/010/01", name, arid, arsize, arburst);
    end
  endtask

  task automatic test_reset();
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    pulse_frame(32'h0, 4, 2, 1);
    tests_run++;
    if (arvalid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_start: arvalid=%b busy=%b, required 1/1", arvalid, busy);
    end
    wait_done("basic", 200);
    tests_run++;
    if (rd_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_err: rd_error=%b, required 0", rd_error);
    end
    tick(3);
  endtask

  task automatic test_backpressure();
    tready_toggle = 1; saw_stall = 0;
    pulse_frame(32'h0, 4, 2, 1);
    wait_done("backpressure", 300);
    tests_run++;
    if (saw_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_rready: rready never dropped with FIFO full, required a drop");
    end
    tready_toggle = 0;
    tick(3);
  endtask

  task automatic test_slow_slave();
    ar_delay = 3; r_gap = 2;
    pulse_frame(32'h0, 4, 2, 1);
    wait_done("slow", 400);
    ar_delay = 0; r_gap = 0;
    tick(3);
  endtask

  task automatic test_busy_ignore();
    pulse_frame(32'h0, 4, 2, 1);
    tick(2);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignore_busy: busy=%b, required 1", busy);
    end
    pulse_frame(32'h40, 4, 2, 0);
    wait_done("ignore", 200);
    tick(10);
    tests_run++;
    if (busy !== 1'b0 || arvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_idle: busy=%b arvalid=%b, required 0/0", busy, arvalid);
    end
  endtask

  task automatic test_rd_error();
    err_beat = 2;
    pulse_frame(32'h0, 4, 2, 1);
    wait_done("error", 200);
    tests_run++;
    if (rd_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL error_set: rd_error=%b, required 1", rd_error);
    end
    err_beat = -1;
    tick(3);
    tests_run++;
    if (rd_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL error_sticky: rd_error=%b, required 1", rd_error);
    end
    pulse_frame(32'h0, 4, 2, 1);
    tests_run++;
    if (rd_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL error_clear: rd_error=%b, required 0", rd_error);
    end
    wait_done("error_next", 200);
    tick(3);
  endtask

  task automatic test_boundaries();
    pulse_frame(32'h100, 1, 3, 1);
    wait_done("width1", 200);
    tick(2);
    pulse_frame(32'hFFFF_FFF8, 4, 2, 1);
    wait_done("wrap", 200);
    tick(2);
    pulse_frame(32'h2000, 256, 1, 1);
    wait_done("width256", 1000);
    tick(3);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    r_gap = 2;
    pulse_frame(32'h0, 4, 2, 1);
    n = 0;
    while (global_beat < 5 && n < 200) begin tick(1); n++; end
    tests_run++;
    if (global_beat < 5) begin
      tests_failed++;
      $display("FAIL midreset_reach: %0d beats, required 5", global_beat);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete(); exp_ar.delete();
    r_gap = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    pulse_frame(32'h0, 4, 2, 1);
    wait_done("after_reset", 200);
    tick(3);
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_backpressure();
    test_slow_slave();
    test_busy_ignore();
    test_rd_error();
    test_boundaries();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
